// File: rtl/id_branch_ctl_pkg.sv
// Shared DLX decode constants, field helpers and pipeline bundles for the ID stage.
// Instruction words use DLX numbering: DLX bit n lives at vector index 31-n.
package id_branch_ctl_pkg;

    localparam logic [31:0] NOP_WORD_C = 32'h5400_0000;
    localparam logic [4:0]  LINK_REG   = 5'd31;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQZ  = 6'h04;
    localparam logic [5:0] OP_BNEZ  = 6'h05;
    localparam logic [5:0] OP_JR    = 6'h12;
    localparam logic [5:0] OP_JALR  = 6'h13;

    typedef enum logic [1:0] {
        ST_START  = 2'd0,
        ST_RUN    = 2'd1,
        ST_SQUASH = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus_four;
        logic        valid;
        logic        link;
    } id_ex_t;

    function automatic logic [5:0] f_op(input logic [31:0] w);
        return w[31:26];
    endfunction

    function automatic logic [4:0] f_rs1(input logic [31:0] w);
        return w[25:21];
    endfunction

    function automatic logic [4:0] f_rs2(input logic [31:0] w);
        return w[20:16];
    endfunction

    function automatic logic [31:0] f_sext16(input logic [31:0] w);
        return {{16{w[15]}}, w[15:0]};
    endfunction

    function automatic logic [31:0] f_sext26(input logic [31:0] w);
        return {{6{w[25]}}, w[25:0]};
    endfunction

endpackage

// File: rtl/id_branch_ctl_if.sv
// Fetch <-> decode bundle: fetched word forward, stall and redirect back.
interface id_branch_ctl_if;

    logic [31:0] instr;
    logic [31:0] pc_plus_four;
    logic        reg_lock;
    logic [31:0] target;
    logic        jump_or_branch;

    modport master (
        output instr,
        output pc_plus_four,
        input  reg_lock,
        input  target,
        input  jump_or_branch
    );

    modport slave (
        input  instr,
        input  pc_plus_four,
        output reg_lock,
        output target,
        output jump_or_branch
    );

endinterface

// File: rtl/id_branch_ctl_branch_resolve.sv
// Combinational DLX control-transfer decode: class, taken flag and target.
module id_branch_ctl_branch_resolve
    import id_branch_ctl_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc_plus_four,
    input  logic [31:0] rs1_val,
    output logic        taken,
    output logic [31:0] target,
    output logic        link,
    output logic        reads_rs1,
    output logic        rtype
);

    logic [5:0] op;
    logic       is_br;
    logic       is_j;
    logic       is_jr;
    logic       rs1_zero;

    assign op       = f_op(instr);
    assign is_br    = (op == OP_BEQZ) || (op == OP_BNEZ);
    assign is_j     = (op == OP_J) || (op == OP_JAL);
    assign is_jr    = (op == OP_JR) || (op == OP_JALR);
    assign rs1_zero = (rs1_val == 32'd0);

    assign link      = (op == OP_JAL) || (op == OP_JALR);
    assign reads_rs1 = is_br || is_jr;
    assign rtype     = (op == OP_RTYPE);

    always_comb begin
        taken  = 1'b0;
        target = pc_plus_four;
        unique case (1'b1)
            is_br: begin
                target = pc_plus_four + f_sext16(instr);
                taken  = (op == OP_BEQZ) ? rs1_zero : !rs1_zero;
            end
            is_j: begin
                target = pc_plus_four + f_sext26(instr);
                taken  = 1'b1;
            end
            is_jr: begin
                target = rs1_val;
                taken  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/id_branch_ctl.sv
// DLX ID-stage branch resolution, hazard stall and ID/EX register.
// Define DELAY_SLOT_EN for one architectural delay slot instead of squashing.
module id_branch_ctl
    import id_branch_ctl_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = NOP_WORD_C
) (
    input  logic                 clk,
    input  logic                 rst_n,
    id_branch_ctl_if.slave       fch,
    output logic [4:0]           rs1_addr,
    input  logic [31:0]          rs1_val,
    input  logic                 ex_reg_write,
    input  logic                 ex_is_load,
    input  logic [4:0]           ex_rd,
    input  logic                 mem_is_load,
    input  logic [4:0]           mem_rd,
    output logic [31:0]          id_instr,
    output logic [31:0]          id_pc_plus_four,
    output logic                 id_valid,
    output logic                 id_link
);

    state_e state_q, state_d;
    id_ex_t idex_q, idex_d;

    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        taken;
    logic [31:0] br_target;
    logic        link;
    logic        reads_rs1;
    logic        rtype;
    logic        load_use;
    logic        br_haz;
    logic        stall;
    logic        redirect;
    logic        issue;
    logic        run;

    assign rs1      = f_rs1(fch.instr);
    assign rs2      = f_rs2(fch.instr);
    assign rs1_addr = rs1;

    id_branch_ctl_branch_resolve u_resolve (
        .instr        (fch.instr),
        .pc_plus_four (fch.pc_plus_four),
        .rs1_val      (rs1_val),
        .taken        (taken),
        .target       (br_target),
        .link         (link),
        .reads_rs1    (reads_rs1),
        .rtype        (rtype)
    );

    // Register 0 is hardwired, so a write to it never creates a dependency.
    assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                      ((ex_rd == rs1) || (rtype && (ex_rd == rs2)));

    assign br_haz = reads_rs1 && (rs1 != 5'd0) &&
                    ((ex_reg_write && (ex_rd == rs1)) ||
                     (mem_is_load && (mem_rd == rs1)));

    always_comb begin
        state_d  = state_q;
        stall    = 1'b0;
        redirect = 1'b0;
        issue    = 1'b0;
        unique case (state_q)
            ST_START: state_d = ST_RUN;
            ST_RUN: begin
                stall    = load_use || br_haz;
                redirect = taken && !stall;
                issue    = !stall;
`ifdef DELAY_SLOT_EN
                state_d  = ST_RUN;
`else
                state_d  = redirect ? ST_SQUASH : ST_RUN;
`endif
            end
            ST_SQUASH: state_d = ST_RUN;
            default:   state_d = ST_START;
        endcase
    end

    assign run                = rst_n && (state_q == ST_RUN);
    assign fch.reg_lock       = rst_n && stall;
    assign fch.jump_or_branch = rst_n && redirect;
    assign fch.target         = run ? br_target : 32'd0;

    always_comb begin
        idex_d.instr        = NOP_WORD;
        idex_d.pc_plus_four = 32'd0;
        idex_d.valid        = 1'b0;
        idex_d.link         = 1'b0;
        if (issue) begin
            idex_d.instr        = fch.instr;
            idex_d.pc_plus_four = fch.pc_plus_four;
            idex_d.valid        = 1'b1;
            idex_d.link         = link;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q             <= ST_START;
            idex_q.instr        <= NOP_WORD;
            idex_q.pc_plus_four <= 32'd0;
            idex_q.valid        <= 1'b0;
            idex_q.link         <= 1'b0;
        end else begin
            state_q <= state_d;
            idex_q  <= idex_d;
        end
    end

    assign id_instr        = idex_q.instr;
    assign id_pc_plus_four = idex_q.pc_plus_four;
    assign id_valid        = idex_q.valid;
    assign id_link         = idex_q.link;

endmodule

// File: tb/tb_id_branch_ctl.sv
// Directed bench for id_branch_ctl: reset, branches, jumps, hazards, squash.
module tb_id_branch_ctl;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1_addr;
    logic [31:0] rs1_val;
    logic        ex_reg_write;
    logic        ex_is_load;
    logic [4:0]  ex_rd;
    logic        mem_is_load;
    logic [4:0]  mem_rd;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus_four;
    logic        id_valid;
    logic        id_link;

    int vectors;
    int miscompares;

    logic        slot_valid_exp;
    logic [31:0] w;

    id_branch_ctl_if fch ();

    id_branch_ctl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fch             (fch.slave),
        .rs1_addr        (rs1_addr),
        .rs1_val         (rs1_val),
        .ex_reg_write    (ex_reg_write),
        .ex_is_load      (ex_is_load),
        .ex_rd           (ex_rd),
        .mem_is_load     (mem_is_load),
        .mem_rd          (mem_rd),
        .id_instr        (id_instr),
        .id_pc_plus_four (id_pc_plus_four),
        .id_valid        (id_valid),
        .id_link         (id_link)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] itype(input logic [5:0] op,
                                          input logic [4:0] rs,
                                          input logic [15:0] imm);
        return {op, rs, 5'd0, imm};
    endfunction

    function automatic logic [31:0] jtype(input logic [5:0] op,
                                          input logic [25:0] off);
        return {op, off};
    endfunction

    function automatic logic [31:0] add_rr(input logic [4:0] rd,
                                           input logic [4:0] rs,
                                           input logic [4:0] rt);
        return {6'h00, rs, rt, rd, 11'h020};
    endfunction

    initial begin
        vectors        = 0;
        miscompares    = 0;
`ifdef DELAY_SLOT_EN
        slot_valid_exp = 1'b1;
`else
        slot_valid_exp = 1'b0;
`endif
        rst_n            = 1'b0;
        rs1_val          = 32'd0;
        ex_reg_write     = 1'b0;
        ex_is_load       = 1'b0;
        ex_rd            = 5'd0;
        mem_is_load      = 1'b0;
        mem_rd           = 5'd0;
        fch.instr        = jtype(6'h02, 26'h10);
        fch.pc_plus_four = 32'h40;
        tick();
        tick();
        #2;
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_instr", id_instr, 32'h5400_0000);
        chk("rst_pc", id_pc_plus_four, 32'd0);
        chk("rst_jb", {31'd0, fch.jump_or_branch}, 32'd0);
        chk("rst_target", fch.target, 32'd0);

        // release: START still bubbles even with a jump in fetch
        tick();
        rst_n = 1'b1;
        #1;
        chk("start_jb", {31'd0, fch.jump_or_branch}, 32'd0);
        chk("start_lock", {31'd0, fch.reg_lock}, 32'd0);
        tick();
        chk("start_bubble", {31'd0, id_valid}, 32'd0);

        // BNEZ with rs1==0: not taken, forwarded
        w = itype(6'h05, 5'd2, 16'h0010);
        fch.instr = w;
        fch.pc_plus_four = 32'h200;
        rs1_val = 32'd0;
        #1;
        chk("bnez_nt_jb", {31'd0, fch.jump_or_branch}, 32'd0);
        chk("bnez_nt_lock", {31'd0, fch.reg_lock}, 32'd0);
        tick();
        chk("bnez_valid", {31'd0, id_valid}, 32'd1);
        chk("bnez_instr", id_instr, w);
        chk("bnez_pc", id_pc_plus_four, 32'h200);

        // BEQZ taken backward
        w = itype(6'h04, 5'd2, 16'hFFF8);
        fch.instr = w;
        fch.pc_plus_four = 32'h104;
        #1;
        chk("beqz_jb", {31'd0, fch.jump_or_branch}, 32'd1);
        chk("beqz_target", fch.target, 32'h0000_00FC);
        tick();
        chk("beqz_issued", {31'd0, id_valid}, 32'd1);
        fch.instr = add_rr(5'd4, 5'd0, 5'd0);
        fch.pc_plus_four = 32'h108;
        #1;
        chk("slot_jb", {31'd0, fch.jump_or_branch}, 32'd0);
        tick();
        chk("slot_valid", {31'd0, id_valid}, {31'd0, slot_valid_exp});

        // BEQZ with nonzero rs1: not taken
        fch.instr = itype(6'h04, 5'd2, 16'h0020);
        rs1_val = 32'd5;
        #1;
        chk("beqz_nt_jb", {31'd0, fch.jump_or_branch}, 32'd0);
        tick();

        // load-use on rs1, then on rs2, then register 0
        w = add_rr(5'd4, 5'd3, 5'd5);
        fch.instr = w;
        ex_is_load = 1'b1;
        ex_rd = 5'd3;
        #1;
        chk("lu_rs1_lock", {31'd0, fch.reg_lock}, 32'd1);
        tick();
        chk("lu_bubble", {31'd0, id_valid}, 32'd0);
        chk("lu_bubble_instr", id_instr, 32'h5400_0000);
        ex_is_load = 1'b0;
        #1;
        chk("lu_clear_lock", {31'd0, fch.reg_lock}, 32'd0);
        tick();
        chk("lu_issue_valid", {31'd0, id_valid}, 32'd1);
        chk("lu_issue_instr", id_instr, w);
        ex_is_load = 1'b1;
        ex_rd = 5'd5;
        #1;
        chk("lu_rs2_lock", {31'd0, fch.reg_lock}, 32'd1);
        tick();
        fch.instr = add_rr(5'd4, 5'd0, 5'd0);
        ex_rd = 5'd0;
        #1;
        chk("lu_r0_lock", {31'd0, fch.reg_lock}, 32'd0);
        tick();
        ex_is_load = 1'b0;

        // JR r7 blocked by EX writer, then MEM load, then resolved
        fch.instr = itype(6'h12, 5'd7, 16'h0000);
        fch.pc_plus_four = 32'h300;
        rs1_val = 32'h0000_1234;
        ex_reg_write = 1'b1;
        ex_rd = 5'd7;
        #1;
        chk("jr_addr", {27'd0, rs1_addr}, 32'd7);
        chk("jr_ex_lock", {31'd0, fch.reg_lock}, 32'd1);
        chk("jr_ex_jb", {31'd0, fch.jump_or_branch}, 32'd0);
        tick();
        chk("jr_bubble", {31'd0, id_valid}, 32'd0);
        ex_reg_write = 1'b0;
        mem_is_load = 1'b1;
        mem_rd = 5'd7;
        #1;
        chk("jr_mem_lock", {31'd0, fch.reg_lock}, 32'd1);
        tick();
        mem_is_load = 1'b0;
        #1;
        chk("jr_lock", {31'd0, fch.reg_lock}, 32'd0);
        chk("jr_jb", {31'd0, fch.jump_or_branch}, 32'd1);
        chk("jr_target", fch.target, 32'h0000_1234);
        tick();
        chk("jr_valid", {31'd0, id_valid}, 32'd1);
        chk("jr_link", {31'd0, id_link}, 32'd0);
        fch.instr = add_rr(5'd4, 5'd0, 5'd0);
        #1;
        chk("jr_slot_jb", {31'd0, fch.jump_or_branch}, 32'd0);
        tick();

        // JAL to address 0
        fch.instr = jtype(6'h03, 26'h3FF_FFF0);
        fch.pc_plus_four = 32'h10;
        #1;
        chk("jal0_jb", {31'd0, fch.jump_or_branch}, 32'd1);
        chk("jal0_target", fch.target, 32'h0000_0000);
        tick();
        chk("jal0_link", {31'd0, id_link}, 32'd1);
        chk("jal0_pc", id_pc_plus_four, 32'h10);
        chk("jal0_valid", {31'd0, id_valid}, 32'd1);
        fch.instr = add_rr(5'd4, 5'd0, 5'd0);
        fch.pc_plus_four = 32'h14;
        tick();

        // JAL off26=3FFFFFC: pc_plus_four + (-4)
        fch.instr = jtype(6'h03, 26'h3FF_FFFC);
        fch.pc_plus_four = 32'h10;
        #1;
        chk("jalc_target", fch.target, 32'h0000_000C);
        tick();
        fch.instr = add_rr(5'd4, 5'd0, 5'd0);
        tick();

        // JALR r9
        fch.instr = itype(6'h13, 5'd9, 16'h0000);
        fch.pc_plus_four = 32'h500;
        rs1_val = 32'h0000_8000;
        #1;
        chk("jalr_addr", {27'd0, rs1_addr}, 32'd9);
        chk("jalr_target", fch.target, 32'h0000_8000);
        tick();
        chk("jalr_link", {31'd0, id_link}, 32'd1);

        // asynchronous reset mid-cycle
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", {31'd0, id_valid}, 32'd0);
        chk("mrst_instr", id_instr, 32'h5400_0000);
        chk("mrst_link", {31'd0, id_link}, 32'd0);
        chk("mrst_jb", {31'd0, fch.jump_or_branch}, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("mrst_start_jb", {31'd0, fch.jump_or_branch}, 32'd0);
        tick();
        chk("mrst_bubble", {31'd0, id_valid}, 32'd0);

        // BNEZ taken after recovery
        w = itype(6'h05, 5'd2, 16'h0010);
        fch.instr = w;
        fch.pc_plus_four = 32'h300;
        rs1_val = 32'd1;
        #1;
        chk("bnez_t_jb", {31'd0, fch.jump_or_branch}, 32'd1);
        chk("bnez_t_target", fch.target, 32'h0000_0310);
        tick();
        chk("bnez_t_instr", id_instr, w);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
